// File: rtl/goertzel_pkg.sv
// Shared types, constants and helpers for the dual-bin Goertzel engine.
package goertzel_pkg;

    // Processing-cycle sequence of the engine.
    typedef enum logic [3:0] {
        IDLE,
        RQ_A,
        WAIT_A,
        GAP,
        RQ_B,
        WAIT_B,
        RUN,
        FIN0,
        FIN1
    } state_t;

    // Coefficients are Q1.15; the recurrence uses 2*cos, hence the one-less shift.
    localparam int COEFF_FRAC = 15;
    localparam int REC_SHIFT  = 14;

    // Widest value the sign-extension helper handles.
    localparam int SEXT_W = 64;

    // Sign-extend the low w bits of v to SEXT_W bits.
    function automatic logic signed [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                                      input int unsigned w);
        logic [SEXT_W-1:0] sh;
        sh = v << (SEXT_W - w);
        return $signed(sh) >>> (SEXT_W - w);
    endfunction

endpackage

// File: rtl/goertzel_bin_acc.sv
// One Goertzel bin: coefficient registers, s1/s2 recurrence state and the
// two-stage finishing pipeline that produces the complex result.
module goertzel_bin_acc
    import goertzel_pkg::*;
#(
    parameter int D_W   = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [D_W-1:0]   cos_i,
    input  logic [D_W-1:0]   sin_i,
    input  logic             step_i,
    input  logic [D_W-1:0]   x_i,
    input  logic             fin0_i,
    input  logic             fin1_i,
    output logic [ACC_W-1:0] re_o,
    output logic [ACC_W-1:0] im_o
);

    localparam int PROD_W = D_W + ACC_W;

    logic signed [D_W-1:0]    cos_q, sin_q;
    logic signed [ACC_W-1:0]  s1_q, s2_q, pc_q, ps_q, re_q, im_q;
    logic signed [ACC_W-1:0]  x_ext, s0_d, pc_d, ps_d, re_d;
    logic signed [PROD_W-1:0] rec_prod, pc_prod, ps_prod;

    // Full-width products, floor shifts and wrapping sums for the next state.
    always_comb begin
        x_ext    = ACC_W'(sext(SEXT_W'(x_i), D_W));
        rec_prod = PROD_W'(cos_q) * PROD_W'(s1_q);
        pc_prod  = PROD_W'(cos_q) * PROD_W'(s2_q);
        ps_prod  = PROD_W'(sin_q) * PROD_W'(s2_q);
        s0_d     = x_ext + ACC_W'(rec_prod >>> REC_SHIFT) - s2_q;
        pc_d     = ACC_W'(pc_prod >>> COEFF_FRAC);
        ps_d     = ACC_W'(ps_prod >>> COEFF_FRAC);
        re_d     = s1_q - pc_q;
    end

    // Coefficient latch, recurrence update and result pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cos_q <= '0;
            sin_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            pc_q  <= '0;
            ps_q  <= '0;
            re_q  <= '0;
            im_q  <= '0;
        end else begin
            if (load_i) begin
                cos_q <= cos_i;
                sin_q <= sin_i;
            end
            if (clear_i) begin
                s1_q <= '0;
                s2_q <= '0;
            end else if (step_i) begin
                s2_q <= s1_q;
                s1_q <= s0_d;
            end
            if (fin0_i) begin
                pc_q <= pc_d;
                ps_q <= ps_d;
            end
            if (fin1_i) begin
                re_q <= re_d;
                im_q <= ps_q;
            end
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;

endmodule

// File: rtl/dual_goertzel_engine.sv
// Dual-bin Goertzel engine: fetches one coefficient pair per bin from the
// feeder, runs both recurrences over a block of samples, then reports both
// complex results with a one-cycle strobe.
//
// Handshakes: coeffs_rq is a one-cycle request; the feeder answers with a
// one-cycle d_ready pulse carrying cos_in/sin_in. A sample transfers on every
// rising edge where sample_valid && sample_ready; sample_ready is high only
// while running, and samples offered at any other time are ignored.
module dual_goertzel_engine
    import goertzel_pkg::*;
#(
    parameter int D_W       = 16,
    parameter int ACC_W     = 32,
    parameter int N_SAMPLES = 256,
    parameter int CNT_W     = 9,
    parameter int TIMEOUT   = 15
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    output logic             busy,
    output logic             coeffs_rq,
    input  logic             d_ready,
    input  logic [D_W-1:0]   sin_in,
    input  logic [D_W-1:0]   cos_in,
    input  logic [D_W-1:0]   sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_a_re,
    output logic [ACC_W-1:0] res_a_im,
    output logic [ACC_W-1:0] res_b_re,
    output logic [ACC_W-1:0] res_b_im,
    output logic             coeff_timeout,
    output state_t           dbg_state
);

    localparam int WT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic [WT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              res_valid_q, res_valid_d;
    logic              timeout_q, timeout_d;
    logic              clear, load_a, load_b, step, fin0, fin1;

    // Next-state logic and per-state control strobes for the two bins.
    always_comb begin
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        res_valid_d = 1'b0;
        timeout_d   = 1'b0;
        clear       = 1'b0;
        load_a      = 1'b0;
        load_b      = 1'b0;
        step        = 1'b0;
        fin0        = 1'b0;
        fin1        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    samp_cnt_d = '0;
                    state_d    = RQ_A;
                end
            end
            RQ_A: begin
                wait_cnt_d = '0;
                state_d    = WAIT_A;
            end
            WAIT_A: begin
                if (d_ready) begin
                    load_a  = 1'b1;
                    state_d = GAP;
                end else if (wait_cnt_q == WT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WT_W'(1);
                end
            end
            GAP: state_d = RQ_B;
            RQ_B: begin
                wait_cnt_d = '0;
                state_d    = WAIT_B;
            end
            WAIT_B: begin
                if (d_ready) begin
                    load_b  = 1'b1;
                    state_d = RUN;
                end else if (wait_cnt_q == WT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WT_W'(1);
                end
            end
            RUN: begin
                if (sample_valid) begin
                    step       = 1'b1;
                    samp_cnt_d = samp_cnt_q + CNT_W'(1);
                    if (samp_cnt_q == CNT_W'(N_SAMPLES - 1)) begin
                        state_d = FIN0;
                    end
                end
            end
            FIN0: begin
                fin0    = 1'b1;
                state_d = FIN1;
            end
            FIN1: begin
                fin1        = 1'b1;
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and the registered one-cycle strobes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            samp_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            res_valid_q <= res_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign coeffs_rq     = (state_q == RQ_A) || (state_q == RQ_B);
    assign sample_ready  = (state_q == RUN);
    assign res_valid     = res_valid_q;
    assign coeff_timeout = timeout_q;
    assign dbg_state     = state_q;

    goertzel_bin_acc #(.D_W(D_W), .ACC_W(ACC_W)) u_bin_a (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .clear_i (clear),
        .load_i  (load_a),
        .cos_i   (cos_in),
        .sin_i   (sin_in),
        .step_i  (step),
        .x_i     (sample_in),
        .fin0_i  (fin0),
        .fin1_i  (fin1),
        .re_o    (res_a_re),
        .im_o    (res_a_im)
    );

    goertzel_bin_acc #(.D_W(D_W), .ACC_W(ACC_W)) u_bin_b (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .clear_i (clear),
        .load_i  (load_b),
        .cos_i   (cos_in),
        .sin_i   (sin_in),
        .step_i  (step),
        .x_i     (sample_in),
        .fin0_i  (fin0),
        .fin1_i  (fin1),
        .re_o    (res_b_re),
        .im_o    (res_b_im)
    );

endmodule

// File: tb/tb_dual_goertzel_engine.sv
// Bench for dual_goertzel_engine with a 4-sample block: reset, handshake
// timing, directed and random arithmetic against a plain-arithmetic model,
// backpressure, coefficient timeout and reset in the middle of a block.
module tb_dual_goertzel_engine;
    import goertzel_pkg::*;

    localparam int D_W     = 16;
    localparam int ACC_W   = 32;
    localparam int N       = 4;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 15;

    // ---------------- clock / reset / DUT ----------------
    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             start = 1'b0;
    logic             d_ready = 1'b0;
    logic [D_W-1:0]   sin_in = '0;
    logic [D_W-1:0]   cos_in = '0;
    logic [D_W-1:0]   sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             busy, coeffs_rq, sample_ready, res_valid, coeff_timeout;
    logic [ACC_W-1:0] res_a_re, res_a_im, res_b_re, res_b_im;
    state_t           dbg_state;

    always #5 sys_clk = ~sys_clk;

    dual_goertzel_engine #(
        .D_W(D_W), .ACC_W(ACC_W), .N_SAMPLES(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .start         (start),
        .busy          (busy),
        .coeffs_rq     (coeffs_rq),
        .d_ready       (d_ready),
        .sin_in        (sin_in),
        .cos_in        (cos_in),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .res_valid     (res_valid),
        .res_a_re      (res_a_re),
        .res_a_im      (res_a_im),
        .res_b_re      (res_b_re),
        .res_b_im      (res_b_im),
        .coeff_timeout (coeff_timeout),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] last_exp[4];
    logic [D_W-1:0]   smp[N];

    // ---------------- reference feeder ----------------
    // Answers each coeffs_rq with a d_ready pulse in the following cycle,
    // handing out pair 0 then pair 1 within one processing cycle.
    bit             feeder_en = 1'b1;
    logic [D_W-1:0] feed_cos[2];
    logic [D_W-1:0] feed_sin[2];
    bit             pend = 1'b0;
    int             fidx = 0;

    always @(negedge sys_clk) begin
        d_ready = 1'b0;
        if (sys_rst || !busy) begin
            pend = 1'b0;
            fidx = 0;
        end else begin
            if (pend) begin
                d_ready = 1'b1;
                cos_in  = feed_cos[fidx % 2];
                sin_in  = feed_sin[fidx % 2];
                fidx++;
                pend = 1'b0;
            end
            if (coeffs_rq && feeder_en) pend = 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"},          busy, 0);
        chk({tag, " coeffs_rq"},     coeffs_rq, 0);
        chk({tag, " sample_ready"},  sample_ready, 0);
        chk({tag, " res_valid"},     res_valid, 0);
        chk({tag, " coeff_timeout"}, coeff_timeout, 0);
        chk({tag, " res_a_re"},      $signed(res_a_re), 0);
        chk({tag, " res_a_im"},      $signed(res_a_im), 0);
        chk({tag, " res_b_re"},      $signed(res_b_re), 0);
        chk({tag, " res_b_im"},      $signed(res_b_im), 0);
    endtask

    // Goertzel over smp[] with 64-bit arithmetic, wrapping the state to
    // 32 bits after every sum and using floor shifts.
    function automatic void model(input logic [D_W-1:0] c_u, input logic [D_W-1:0] s_u,
                                  output int re, output int im);
        longint c, s, s0, s1, s2;
        c  = longint'($signed(c_u));
        s  = longint'($signed(s_u));
        s1 = 0;
        s2 = 0;
        for (int i = 0; i < N; i++) begin
            s0 = longint'($signed(smp[i])) + ((c * s1) >>> 14) - s2;
            s0 = longint'(int'(s0));
            s2 = s1;
            s1 = s0;
        end
        re = int'(s1 - ((c * s2) >>> 15));
        im = int'((s * s2) >>> 15);
    endfunction

    // ---------------- driver: one full processing cycle ----------------
    // mode 0: sample_valid always high; 1: toggling; 2: random.
    task automatic run_block(input string tag, input logic [D_W-1:0] ca, input logic [D_W-1:0] sa,
                             input logic [D_W-1:0] cb, input logic [D_W-1:0] sb,
                             input int mode, input bit chk_timing);
        int k, idx, last_k, rv_k, nrv, first_sr, sr_late, nrq, rq1, rq2;
        int are, aim, bre, bim;
        bit v;
        logic [ACC_W-1:0] e;
        model(ca, sa, are, aim);
        model(cb, sb, bre, bim);
        exp_q.push_back(are);
        exp_q.push_back(aim);
        exp_q.push_back(bre);
        exp_q.push_back(bim);
        feed_cos[0] = ca;
        feed_sin[0] = sa;
        feed_cos[1] = cb;
        feed_sin[1] = sb;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        k = 1; idx = 0; last_k = -100; rv_k = -100; nrv = 0;
        first_sr = -1; sr_late = 0; nrq = 0; rq1 = -1; rq2 = -1;
        while (k < 300) begin
            if (coeffs_rq) begin
                nrq++;
                if (nrq == 1) rq1 = k;
                else if (nrq == 2) rq2 = k;
            end
            if (sample_ready && first_sr < 0) first_sr = k;
            if (sample_ready && idx >= N) sr_late++;
            if (k == rv_k + 1) begin
                chk({tag, " res_valid_one_cycle"}, res_valid, 0);
                break;
            end
            if (res_valid) begin
                nrv++;
                rv_k = k;
                chk({tag, " busy_at_res_valid"}, busy, 0);
                chk({tag, " res_valid_latency"}, rv_k, last_k + 3);
                if (exp_q.size() >= 4) begin
                    e = exp_q.pop_front(); last_exp[0] = e;
                    chk({tag, " res_a_re"}, $signed(res_a_re), $signed(e));
                    e = exp_q.pop_front(); last_exp[1] = e;
                    chk({tag, " res_a_im"}, $signed(res_a_im), $signed(e));
                    e = exp_q.pop_front(); last_exp[2] = e;
                    chk({tag, " res_b_re"}, $signed(res_b_re), $signed(e));
                    e = exp_q.pop_front(); last_exp[3] = e;
                    chk({tag, " res_b_im"}, $signed(res_b_im), $signed(e));
                end
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = k[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (idx >= N) v = 1'b1;
            sample_valid = v;
            sample_in    = (idx < N) ? smp[idx] : D_W'($urandom);
            if (v && sample_ready && idx < N) begin
                idx++;
                if (idx == N) last_k = k;
            end
            @(negedge sys_clk);
            k++;
        end
        sample_valid = 1'b0;
        chk({tag, " res_valid_count"}, nrv, 1);
        chk({tag, " coeffs_rq_count"}, nrq, 2);
        chk({tag, " samples_accepted"}, idx, N);
        chk({tag, " sample_ready_after_last"}, sr_late, 0);
        if (chk_timing) begin
            chk({tag, " first_coeffs_rq_cycle"}, rq1, 1);
            chk({tag, " second_coeffs_rq_cycle"}, rq2, 4);
            chk({tag, " first_sample_ready_cycle"}, first_sr, 6);
        end
    endtask

    task automatic set_arith_samples();
        smp[0] = 16'd1;
        smp[1] = 16'd0;
        smp[2] = 16'hFFFF;
        smp[3] = 16'd0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k, idx, to_k, nto, nrv;

        // Reset held 3 cycles with start asserted: everything stays cleared.
        sys_rst = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check_zero($sformatf("reset%0d", i));
        end
        sys_rst = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("idle coeffs_rq", coeffs_rq, 0);
            chk("idle busy", busy, 0);
        end

        // Directed arithmetic with handshake timing.
        set_arith_samples();
        run_block("arith", 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 0, 1'b1);
        chk("arith_const a_re", $signed(res_a_re), 0);
        chk("arith_const a_im", $signed(res_a_im), -2);
        chk("arith_const b_re", $signed(res_b_re), -2);
        chk("arith_const b_im", $signed(res_b_im), 0);

        // Backpressure: toggling sample_valid must give the same results.
        run_block("toggle", 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 1, 1'b0);

        // Random coefficients, samples and valid pattern.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) smp[i] = D_W'($urandom);
            run_block($sformatf("rand%0d", r), D_W'($urandom), D_W'($urandom),
                      D_W'($urandom), D_W'($urandom), 2, 1'b0);
        end

        // Timeout: feeder silent.
        feeder_en = 1'b0;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        k = 1; to_k = -1; nto = 0; nrv = 0;
        while (k < 60) begin
            if (coeff_timeout) begin
                nto++;
                if (to_k < 0) begin
                    to_k = k;
                    chk("timeout busy", busy, 0);
                end
            end
            if (res_valid) nrv++;
            @(negedge sys_clk);
            k++;
        end
        chk("timeout cycle", to_k, TIMEOUT + 2);
        chk("timeout pulse count", nto, 1);
        chk("timeout no res_valid", nrv, 0);
        chk("timeout held a_re", $signed(res_a_re), $signed(last_exp[0]));
        chk("timeout held a_im", $signed(res_a_im), $signed(last_exp[1]));
        chk("timeout held b_re", $signed(res_b_re), $signed(last_exp[2]));
        chk("timeout held b_im", $signed(res_b_im), $signed(last_exp[3]));
        feeder_en = 1'b1;

        // A new start after the timeout works normally.
        set_arith_samples();
        run_block("after_timeout", 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 0, 1'b1);

        // Reset in the middle of RUN after two accepted samples.
        feed_cos[0] = 16'h0000; feed_sin[0] = 16'h7FFF;
        feed_cos[1] = 16'h7FFF; feed_sin[1] = 16'h0000;
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        idx = 0;
        k = 0;
        while (idx < 2 && k < 50) begin
            sample_valid = 1'b1;
            sample_in    = smp[idx];
            if (sample_ready) idx++;
            @(negedge sys_clk);
            k++;
        end
        chk("midrun samples before reset", idx, 2);
        sys_rst      = 1'b1;
        sample_valid = 1'b0;
        start        = 1'b1;
        @(negedge sys_clk);
        check_zero("midrun_reset0");
        @(negedge sys_clk);
        check_zero("midrun_reset1");
        sys_rst = 1'b0;
        start   = 1'b0;
        run_block("after_midrun_reset", 16'h0000, 16'h7FFF, 16'h7FFF, 16'h0000, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
